// File: rtl/reduce_flag_pipe_pkg.sv
// Shared definitions for the reduce_flag_pipe stage: flag bit positions and
// the flag-vector type used by the pipeline, the flag calculator and the bench.
package reduce_flag_pipe_pkg;

  localparam int NUM_FLAGS = 8;

  // Bit position of each reduction flag inside the flag vector.
  localparam int FLAG_AND_OR   = 0;  // &a | &b
  localparam int FLAG_OR_AND   = 1;  // |a & |b
  localparam int FLAG_XOR_XOR  = 2;  // ^a ^ ^b
  localparam int FLAG_AND_BW   = 3;  // &(a & b)
  localparam int FLAG_OR_BW    = 4;  // |(a | b)
  localparam int FLAG_XOR_BW   = 5;  // ^(a ^ b)
  localparam int FLAG_AND_SUM  = 6;  // &(a + b), carry dropped
  localparam int FLAG_OR_DIFF  = 7;  // |(a - b), borrow dropped

  typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/reduce_flag_pipe_calc.sv
// Purely combinational reduction-flag calculator: one operand pair in,
// eight flags out. Sum and difference wrap at WIDTH bits.
module reduce_flag_calc
  import reduce_flag_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output flags_t           flags
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  // Evaluate all eight reductions from the current operands.
  // NOTE: every output of an always_comb gets a default before any branch so no latch is inferred.
  always_comb begin
    sum   = a + b;
    diff  = a - b;
    flags = '0;
    flags[FLAG_AND_OR]  = (&a) | (&b);
    flags[FLAG_OR_AND]  = (|a) & (|b);
    flags[FLAG_XOR_XOR] = (^a) ^ (^b);
    flags[FLAG_AND_BW]  = &(a & b);
    flags[FLAG_OR_BW]   = |(a | b);
    flags[FLAG_XOR_BW]  = ^(a ^ b);
    flags[FLAG_AND_SUM] = &sum;
    flags[FLAG_OR_DIFF] = |diff;
  end

endmodule

// File: rtl/reduce_flag_pipe.sv
// Two-stage valid/ready pipeline: S1 captures an operand pair, S2 holds the
// reduction flags computed from S1. Per-flag saturating hit counters advance
// on every output transfer.
module reduce_flag_pipe
  import reduce_flag_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_FLAGS-1:0]       out_flags,
  input  logic                       clr_counts,
  output logic [NUM_FLAGS*CNT_W-1:0] hit_counts
);

  // Stage 1: captured operands.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: registered flags.
  logic             s2_valid_q, s2_valid_d;
  flags_t           s2_flags_q, s2_flags_d;

  logic   s1_adv;
  logic   s2_adv;
  logic   out_xfer;
  flags_t calc_flags;

  reduce_flag_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .flags (calc_flags)
  );

  // Handshake: a stage may load when it is empty or its contents move on.
  always_comb begin
    s2_adv    = !s2_valid_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    in_ready  = s1_adv;
    out_valid = s2_valid_q;
    out_flags = s2_flags_q;
    out_xfer  = s2_valid_q && out_ready;
  end

  // Next-state for both stages; stalled stages hold their contents.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_flags_d = s2_flags_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_flags_d = calc_flags;
    end
  end

  // Valid bits: cleared by reset so in-flight pairs are dropped.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Data registers: qualified by the valid bits, so they carry no reset.
  // NOTE: leaving payload flops unreset is safe here because nothing reads them while their valid is low.
  always_ff @(posedge clk) begin
    s1_a_q     <= s1_a_d;
    s1_b_q     <= s1_b_d;
    s2_flags_q <= s2_flags_d;
  end

  // One saturating hit counter per flag; a clear overrides a coincident count.
  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count a set flag on each output transfer, sticking at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_counts) begin
        cnt_d = '0;
      end else if (out_xfer && s2_flags_q[i] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign hit_counts[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: doc/reduce_flag_pipe.md
Name: reduce_flag_pipe

Overview:
- Pipelined, handshaked stage that accepts a stream of operand pairs (a, b) and produces the eight reduction flags of the combinational reduction test set.
- Also keeps per-flag saturating hit counters.
- Sits between an operand source and a flag sink; used to exercise reductions under valid/ready backpressure rather than purely combinationally.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- CNT_W, 8, width of each per-flag hit counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  stage can accept the pair this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  flags word present.
- out_ready  input  1  sink accepts flags this cycle.
- out_flags  output  8  flag vector, bit i = flag fi.
- clr_counts  input  1  synchronous clear of all hit counters.
- hit_counts  output  8*CNT_W  counter i in bits [i*CNT_W +: CNT_W].

Behaviour:
- Flag definitions, all evaluated at WIDTH bits, arithmetic truncated modulo 2^WIDTH:
  - f0 = &a | &b
  - f1 = |a & |b
  - f2 = ^a ^ ^b
  - f3 = &(a & b)
  - f4 = |(a | b)
  - f5 = ^(a ^ b)
  - f6 = &(a + b), sum truncated, carry discarded
  - f7 = |(a - b), difference truncated, borrow discarded
- Two register stages:
  - S1 holds the captured operands plus s1_valid.
  - S2 holds the computed flags plus s2_valid.
  - Flags are computed combinationally from S1 and registered into S2.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready.
  - out_valid = s2_valid. out_flags = S2 flags.
- Latency: a pair accepted at edge N appears on out_valid/out_flags after edge N+1, first sampleable at N+2. Sustained throughput is one pair per cycle with out_ready held high.
- No bubbles are inserted: with out_ready high and in_valid continuous, one result completes per cycle.
- Backpressure:
  - While out_ready = 0 and both stages are full, in_ready = 0.
  - S1 and S2 contents hold stable, and out_flags does not change while out_valid && !out_ready.
- Data regs need no reset. Valids do.
- Counters:
  - On each output transfer, counter i increments if out_flags[i] = 1.
  - Saturate at 2^CNT_W-1; no wrap.
- clr_counts:
  - Sets all counters to 0 on the next edge.
  - If it coincides with an output transfer, clear wins and that transfer is not counted.
  - Does not affect the pipeline.
- Reset:
  - s1_valid = 0, s2_valid = 0, so out_valid = 0 and in_ready = 1 the cycle after.
  - All counters = 0.
  - out_flags value is don't-care while out_valid = 0.
  - Reset mid-stream discards in-flight pairs without producing output.

Decomposition:
- Shared package/include holds flag bit index constants FLAG_AND_OR=0 … FLAG_OR_DIFF=7 and NUM_FLAGS=8.
- One sub-module, reduce_flag_calc: purely combinational, operands in, 8 flags out. It is reused by the bench's reference model.
- Counters are a generate loop in the top.

Test Plan:
- Reset then single pair a=0xFF, b=0xFF, out_ready=1 -> out_valid high two cycles later, out_flags=0x1B; hit_counts bits 0, 1, 3, 4 equal 1, others 0.
- Pair a=0x01, b=0x00 -> out_flags=0xB4.
- Pair a=0x80, b=0x7F -> out_flags=0xD2, covering truncated sum 0xFF and difference 0x01.
- Back-to-back stream of 3 pairs with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts.
  - out_flags is held at the first result.
  - Releasing out_ready delivers all 3 in order with no loss or duplicate.
- CNT_W=2, push 5 pairs of 0xFF/0xFF -> counter 0 saturates at 3. Assert clr_counts in the same cycle as a transfer -> counters read 0 next cycle.
- Assert rst with both stages full -> next cycle out_valid=0, in_ready=1, counters 0. No stale result emitted after rst drops.
